// File: rtl/single_ifetch.sv
// single_ifetch: instruction fetch stage of the single-cycle MIPS core.
// It owns the PC, fetches one word at a time over a req/ack handshake and holds
// the fetched word for the datapath until the datapath retires it.
// The optional wait-cycle counter is enabled by defining IFETCH_PERF_CNT_EN.
module single_ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [15:0] imm16
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_wait_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic        req_q;
  logic        valid_q;

  logic [31:0] pc_plus4_d;
  logic [31:0] next_pc_d;
  logic        retire_d;

  // Branch target: the word offset is scaled to bytes and added with 32-bit
  // wrap-around, so negative offsets step backwards through the address space.
  function automatic logic [31:0] branch_target(input logic [31:0] pc4,
                                                input logic [31:0] word_off);
    logic signed [31:0] off_s;
    logic signed [31:0] sum_s;
    off_s = $signed(word_off);
    sum_s = $signed(pc4) + (off_s <<< 2);
    return $unsigned(sum_s);
  endfunction

  // J-type target keeps the 256 MB region of the delay-slot address.
  function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                              input logic [25:0] index);
    return {pc4[31:28], index, 2'b00};
  endfunction

  assign pc_plus4_d = pc_q + 32'd4;
  assign retire_d   = (state_q == VALID) && !stall;

  // Select the PC of the instruction after the current one; jump beats branch.
  always_comb begin
    next_pc_d = pc_plus4_d;
    if (jump) begin
      next_pc_d = jump_target(pc_plus4_d, jump_index);
    end else if (branch_taken) begin
      next_pc_d = branch_target(pc_plus4_d, branch_offset);
    end
  end

  // Fetch FSM with registered request/valid outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0000_0000;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
          valid_q <= 1'b0;
        end
        FETCH: begin
          // The address stays on pc_q until memory answers.
          if (imem_ack) begin
            inst_q  <= imem_rdata;
            state_q <= VALID;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        VALID: begin
          // A stalled datapath keeps inst/pc frozen; late acks are ignored.
          if (retire_d) begin
            pc_q    <= next_pc_d;
            state_q <= FETCH;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] perf_cnt_q;
  logic [31:0] perf_cnt_d;
  logic        wait_cycle_d;

  assign wait_cycle_d = ((state_q == FETCH) && !imem_ack) ||
                        ((state_q == VALID) && stall);
  assign perf_cnt_d   = wait_cycle_d ? perf_cnt_q + 32'd1 : perf_cnt_q;

  // Count cycles lost to memory latency or datapath stalls; wraps at 2^32.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_cnt_q <= 32'h0000_0000;
    end else begin
      perf_cnt_q <= perf_cnt_d;
    end
  end

  assign perf_wait_cnt = perf_cnt_q;
`endif

  assign imem_addr  = pc_q;
  assign imem_req   = req_q;
  assign inst       = inst_q;
  assign inst_valid = valid_q;
  assign pc         = pc_q;
  assign pc_plus4   = pc_plus4_d;
  assign imm16      = inst_q[15:0];

endmodule
